// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic phase timer: phase codes, lamp patterns
// and the phase-to-lamp decode.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    function automatic logic [2:0] lamp_of(input phase_t ph);
        case (ph)
            PH_GREEN:  lamp_of = LAMP_G;
            PH_YELLOW: lamp_of = LAMP_Y;
            default:   lamp_of = LAMP_R;
        endcase
    endfunction

endpackage

// File: rtl/addergen_st.sv
// Structural ripple-carry adder built from a chain of full-adder cells.
module addergen_st #(
    parameter int NBITS = 8
) (
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic             cin,
    output logic [NBITS-1:0] r,
    output logic             cout
);

    logic [NBITS:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < NBITS; i++) begin : g_fa
        assign r[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[NBITS];

endmodule

// File: rtl/traffic_phase_timer.sv
// RED -> GREEN -> YELLOW phase sequencer with tick-based durations and
// pedestrian early termination of GREEN; all outputs registered.
module traffic_phase_timer
    import traffic_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MIN_GREEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ped_req,
    input  logic [WIDTH-1:0] red_len,
    input  logic [WIDTH-1:0] green_len,
    input  logic [WIDTH-1:0] yellow_len,
    output logic [2:0]       light,
    output logic [1:0]       phase,
    output logic [WIDTH-1:0] count,
    output logic             phase_done,
    output logic             ped_ack
);

    localparam logic [WIDTH-1:0] MIN_G = WIDTH'(MIN_GREEN);

    phase_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_cur_len;
    logic [2:0]       r_light;
    logic             r_phase_done;
    logic             r_ped_pending;

    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_len_eff;
    logic             w_early;
    logic             w_end;
    logic             w_legal;
    phase_t           w_adv_state;
    logic [WIDTH-1:0] w_adv_len;
    phase_t           w_next_state;
    logic [WIDTH-1:0] w_next_count;
    logic [WIDTH-1:0] w_next_len;
    logic             w_next_done;
    logic             w_next_ped;

    addergen_st #(.NBITS(WIDTH)) u_inc (
        .a    (r_count),
        .b    ({WIDTH{1'b0}}),
        .cin  (1'b1),
        .r    (w_sum),
        .cout (w_ovf)
    );

    // A programmed length of zero behaves as a one-tick phase.
    assign w_len_eff = (r_cur_len == '0) ? WIDTH'(1) : r_cur_len;
    assign w_early   = (r_state == PH_GREEN) && (r_ped_pending || ped_req) && (w_sum >= MIN_G);
    assign w_end     = (w_sum == w_len_eff) || w_ovf || w_early;

    always_comb begin
        w_adv_state  = PH_RED;
        w_adv_len    = red_len;
        w_legal      = 1'b1;
        w_next_state = r_state;
        w_next_count = r_count;
        w_next_len   = r_cur_len;
        w_next_done  = 1'b0;

        case (r_state)
            PH_RED: begin
                w_adv_state = PH_GREEN;
                w_adv_len   = green_len;
            end
            PH_GREEN: begin
                w_adv_state = PH_YELLOW;
                w_adv_len   = yellow_len;
            end
            PH_YELLOW: begin
                w_adv_state = PH_RED;
                w_adv_len   = red_len;
            end
            default: w_legal = 1'b0;
        endcase

        // The unused encoding returns to RED without waiting for a tick.
        if (!w_legal) begin
            w_next_state = PH_RED;
            w_next_count = '0;
            w_next_len   = red_len;
            w_next_done  = 1'b1;
        end else if (tick) begin
            if (w_end) begin
                w_next_state = w_adv_state;
                w_next_count = '0;
                w_next_len   = w_adv_len;
                w_next_done  = 1'b1;
            end else begin
                w_next_count = w_sum;
            end
        end

        // Entering RED clears a pending request even if one arrives this cycle.
        if (w_next_state == PH_RED && r_state != PH_RED) begin
            w_next_ped = 1'b0;
        end else begin
            w_next_ped = r_ped_pending | ped_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= PH_RED;
            r_count       <= '0;
            r_cur_len     <= red_len;
            r_light       <= LAMP_R;
            r_phase_done  <= 1'b0;
            r_ped_pending <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_count       <= w_next_count;
            r_cur_len     <= w_next_len;
            r_light       <= lamp_of(w_next_state);
            r_phase_done  <= w_next_done;
            r_ped_pending <= w_next_ped;
        end
    end

    assign light      = r_light;
    assign phase      = r_state;
    assign count      = r_count;
    assign phase_done = r_phase_done;
    assign ped_ack    = r_ped_pending;

endmodule

// File: doc/traffic_phase_timer.md
# traffic_phase_timer

Registered phase sequencer for one signal head: cycles RED → GREEN → YELLOW → RED with per-phase durations counted in `tick` units, and supports pedestrian early-termination of GREEN. It sits directly upstream and downstream of the structural ripple adder `addergen_st`. It drives the adder's operands (current count, zero, carry-in = 1) and consumes the sum and carry-out as its next-count value. Its light outputs feed the intersection controller and lamp drivers.

## Interface
- `WIDTH`, default 8: count and duration width in bits.
- `MIN_GREEN`, default 4: minimum GREEN ticks before a pedestrian request may end GREEN.
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  single-cycle count enable (e.g. 1 Hz strobe).
- `ped_req`  in  1  pedestrian request, level or pulse.
- `red_len`  in  WIDTH  RED duration in ticks.
- `green_len`  in  WIDTH  GREEN duration in ticks.
- `yellow_len`  in  WIDTH  YELLOW duration in ticks.
- `light`  out  3  one-hot {R,Y,G}, registered.
- `phase`  out  2  encoded state: 0 = RED, 1 = GREEN, 2 = YELLOW.
- `count`  out  WIDTH  ticks elapsed in the current phase.
- `phase_done`  out  1  one-cycle pulse on every phase change.
- `ped_ack`  out  1  high while a pedestrian request is pending.

## Operation
- FSM states and next state:
  - RED (0) → GREEN (1).
  - GREEN (1) → YELLOW (2).
  - YELLOW (2) → RED (0).
  - Encoding 3 is illegal and recovers to RED on the next clock.
- `light` decodes from state: RED = 3'b100, YELLOW = 3'b010, GREEN = 3'b001.
- Duration shadow register `cur_len`:
  - Loaded with the next phase's `*_len` input on each transition.
  - Loaded with `red_len` during reset.
  - Mid-phase changes to `*_len` have no effect until the next transition.
- A length of 0 is treated as 1.
- Incrementer path: adder `a = count`, `b = 0`, `cin = 1`; `sum = r`, `ovf = cout`.
- On `tick`:
  - If `sum == cur_len`, or `ovf`, or the early-end condition holds: advance state, `count ← 0`, pulse `phase_done`.
  - Otherwise: `count ← sum`.
- Without `tick`, `count` and state hold.
- Early-end condition: state is GREEN, `(ped_pending | ped_req)` is true, and `sum >= MIN_GREEN`.
- `ped_pending` flag:
  - Set on any cycle with `ped_req` = 1.
  - Cleared on the cycle state enters RED; clearing has priority over a set in that same cycle.
  - Drives `ped_ack`.
- `ovf` can only occur if `cur_len` reaches 2^WIDTH. This is impossible by width, but it is kept as a defensive forced transition.
- Width rules:
  - Compare `sum` against `cur_len` at WIDTH bits.
  - `MIN_GREEN` must be ≤ 2^WIDTH−1.
  - If `MIN_GREEN ≥ green_len`, early end never shortens GREEN.

## Timing
- Reset values: state RED, `light` = 3'b100, `phase` = 0, `count` = 0, `phase_done` = 0, `ped_ack` = 0, `cur_len` = `red_len`.
- `rst` has priority over `tick` and `ped_req` in the same cycle.
- Reset asserted mid-phase aborts the phase, and RED restarts from count 0.
- Latency: `tick` sampled at edge n updates `count`, `phase`, `light` and `phase_done` at edge n (visible cycle n+1). Outputs are all registered; there is no combinational input-to-output path.
- A phase of length L lasts exactly L ticks. `count` shows 0 … L−1, and the tick that would produce L causes the transition.
- `phase_done` is high for exactly one clock after each transition, even if `tick` is held high continuously.
- Back-to-back ticks every cycle are legal: a length-1 phase changes every cycle, and `phase_done` stays high continuously.
- `ped_req` arriving on the same cycle as a qualifying GREEN tick ends GREEN on that tick.

## Structure
- Shared package `traffic_pkg`:
  - Phase encoding constants `PH_RED`, `PH_GREEN`, `PH_YELLOW`.
  - Lamp one-hot constants `LAMP_R`, `LAMP_Y`, `LAMP_G`.
- One sub-module instance: `addergen_st` with `NBITS = WIDTH`, named `u_inc`, as the incrementer.
- Everything else (FSM, `cur_len`, `ped_pending`, `phase_done`) is flat in this module.

## Test plan
- Reset, then `red_len` = 3, `green_len` = 5, `yellow_len` = 2, with `tick` every 4 clocks.
  - RED shows counts 0,1,2, then GREEN for 5 ticks, YELLOW for 2, then back to RED.
  - `phase_done` pulses once per transition, 3 per full cycle.
- `green_len` = 10, `MIN_GREEN` = 4, `ped_req` pulsed at GREEN count 1.
  - `ped_ack` rises the next clock.
  - GREEN ends on the tick producing sum 4, then YELLOW follows.
  - `ped_ack` clears on RED entry.
- `ped_req` held high throughout RED only.
  - `ped_pending` stays set into GREEN, and GREEN ends at count 3 → YELLOW on the 4th tick.
- All lengths 0 with `tick` held high.
  - Each phase lasts 1 tick: R→G→Y→R on consecutive clocks, `phase_done` continuously high.
- Change `green_len` from 5 to 2 while in GREEN at count 1.
  - GREEN still lasts 5 ticks; the next GREEN lasts 2.
- Assert `rst` in YELLOW at count 1, together with `tick`.
  - Next clock: `light` = 3'b100, `count` = 0, `phase_done` = 0, `ped_ack` = 0.
